wb_addr_decoder: RTL and testbench

- Parametrised Wishbone address decoder and response multiplexer with N slave ports. Sits between the 16-bit bridge output and the peripherals (RAM, GPIA, KIA, ROM, and later devices).
- Decodes a configurable address field to select a slave, gates cyc/stb to that slave, and muxes ack/data back to the master.
- Improves on the purely combinational decode with a registered slave select, a single-cycle fill response for unclaimed addresses, an ack-timeout watchdog, and a sticky error capture register.

---
 rtl/kestrel_bus_pkg.sv | 22 ++
 rtl/wb_ack_watchdog.sv | 43 ++++
 rtl/wb_addr_decoder.sv | 177 +++++++++++++++++
 tb/tb_wb_addr_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kestrel_bus_pkg.sv
// Shared definitions for the Kestrel 16-bit Wishbone bus fabric.
// Holds the decoder FSM state encoding, the fill pattern returned for
// faulting accesses, and the default device IDs of the standard
// peripheral set.
package kestrel_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } bus_state_e;

    // Low byte of the fill word; decodes as an illegal instruction so a
    // fetch from a faulting address traps instead of executing garbage.
    localparam logic [7:0] FILL_LO = 8'hEE;

    localparam logic [3:0] RAM_ID  = 4'h0;
    localparam logic [3:0] GPIA_ID = 4'h1;
    localparam logic [3:0] KIA_ID  = 4'h2;
    localparam logic [3:0] ROM_ID  = 4'hF;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Acknowledge watchdog: counts cycles a bus transfer has been waiting
// and flags expiry on the TMO-th waiting cycle.
// Ports:
//   clk_i     system clock
//   reset_i   asynchronous active-low reset
//   start_i   a transfer is waiting for ack this cycle (count it)
//   clr_i     return the counter to zero (idle, ack or abort)
//   expire_o  this waiting cycle is the last one allowed
module wb_ack_watchdog #(
    parameter int TMO = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic start_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [15:0] LAST = 16'(TMO - 1);

    logic [15:0] cnt_q, cnt_d;

    assign expire_o = start_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        // Expiry rearms the counter so the next transfer starts from zero.
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_addr_decoder.sv
// Wishbone address decoder and response multiplexer.
// Decodes m_adr_i[FLSB +: FBITS] against per-slave IDs, routes cyc/stb
// to the selected slave and muxes its ack/data back. Unclaimed addresses
// and ack timeouts get a one-cycle error response with a fill word, and
// the first such fault is held in a sticky capture register.
// Ports:
//   clk_i, reset_i          clock, asynchronous active-low reset
//   m_adr_i/m_cyc_i/m_stb_i master request
//   m_dat_o/m_ack_o/m_err_o master response
//   s_cyc_o/s_stb_o         per-slave cycle/strobe
//   s_ack_i/s_dat_i         per-slave acknowledge and read data
//   err_valid_o/err_tmo_o/err_adr_o  sticky fault capture
//   err_clr_i               one-cycle clear of the fault capture
module wb_addr_decoder
    import kestrel_bus_pkg::*;
#(
    parameter int                         NSLAVES = 4,
    parameter int                         FBITS   = 4,
    parameter int                         FLSB    = 56,
    parameter logic [NSLAVES*FBITS-1:0]   IDS     = {ROM_ID, KIA_ID, GPIA_ID, RAM_ID},
    parameter int                         TMO     = 255,
    parameter int                         DW      = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [63:1]             m_adr_i,
    input  logic                    m_cyc_i,
    input  logic                    m_stb_i,
    output logic [DW-1:0]           m_dat_o,
    output logic                    m_ack_o,
    output logic                    m_err_o,
    output logic [NSLAVES-1:0]      s_cyc_o,
    output logic [NSLAVES-1:0]      s_stb_o,
    input  logic [NSLAVES-1:0]      s_ack_i,
    input  logic [NSLAVES*DW-1:0]   s_dat_i,
    output logic                    err_valid_o,
    output logic                    err_tmo_o,
    output logic [63:1]             err_adr_o,
    input  logic                    err_clr_i
);

    localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

    bus_state_e    state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [63:1]   fill_q, fill_d;
    logic          tmo_q, tmo_d;
    logic          err_valid_q, err_valid_d;
    logic          err_tmo_q, err_tmo_d;
    logic [63:1]   err_adr_q, err_adr_d;

    logic [FBITS-1:0] field;
    logic             hit;
    logic [SW-1:0]    hit_idx;
    logic             req;
    logic             wd_start, wd_clr, wd_expire;

    assign field = m_adr_i[FLSB +: FBITS];
    assign req   = m_cyc_i && m_stb_i;

    // Scan from the top so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NSLAVES - 1; k >= 0; k--) begin
            if (field == IDS[k*FBITS +: FBITS]) begin
                hit     = 1'b1;
                hit_idx = SW'(k);
            end
        end
    end

    wb_ack_watchdog #(
        .TMO (TMO)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (wd_start),
        .clr_i    (wd_clr),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        fill_d   = fill_q;
        tmo_d    = tmo_q;
        wd_start = 1'b0;
        wd_clr   = 1'b1;
        s_cyc_o  = '0;
        s_stb_o  = '0;
        m_ack_o  = 1'b0;
        m_err_o  = 1'b0;
        m_dat_o  = '0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Address is kept for both fault kinds (unclaimed and timeout).
                    fill_d = m_adr_i;
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = ST_BUSY;
                    end else begin
                        tmo_d   = 1'b0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUSY: begin
                s_cyc_o[sel_q] = m_cyc_i;
                s_stb_o[sel_q] = m_stb_i;
                m_ack_o        = s_ack_i[sel_q];
                m_dat_o        = s_dat_i[int'(sel_q)*DW +: DW];
                if (s_ack_i[sel_q]) begin
                    state_d = ST_IDLE;
                end else if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    wd_clr   = 1'b0;
                    wd_start = 1'b1;
                    if (wd_expire) begin
                        tmo_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                m_ack_o = 1'b1;
                m_err_o = 1'b1;
                m_dat_o = DW'({fill_q[63:56], FILL_LO});
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A capture in the same cycle as a clear overrides the clear.
    always_comb begin
        err_valid_d = err_valid_q;
        err_tmo_d   = err_tmo_q;
        err_adr_d   = err_adr_q;
        if (err_clr_i) begin
            err_valid_d = 1'b0;
        end
        if ((state_d == ST_RESP) && (!err_valid_q || err_clr_i)) begin
            err_valid_d = 1'b1;
            err_tmo_d   = tmo_d;
            err_adr_d   = fill_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            fill_q      <= '0;
            tmo_q       <= 1'b0;
            err_valid_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_adr_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            fill_q      <= fill_d;
            tmo_q       <= tmo_d;
            err_valid_q <= err_valid_d;
            err_tmo_q   <= err_tmo_d;
            err_adr_q   <= err_adr_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_tmo_o   = err_tmo_q;
    assign err_adr_o   = err_adr_q;

endmodule

// File: tb/tb_wb_addr_decoder.sv
module tb_wb_addr_decoder;
    import kestrel_bus_pkg::*;

    localparam int NS = 4;
    localparam int DW = 16;
    localparam logic [54:0] LOWB = 55'h0123456789ABC;

    logic           clk_i;
    logic           reset_i;
    logic [63:1]    m_adr_i;
    logic           m_cyc_i;
    logic           m_stb_i;
    logic [DW-1:0]  m_dat_o;
    logic           m_ack_o;
    logic           m_err_o;
    logic [NS-1:0]  s_cyc_o;
    logic [NS-1:0]  s_stb_o;
    logic [NS-1:0]  s_ack_i;
    logic [NS*DW-1:0] s_dat_i;
    logic           err_valid_o;
    logic           err_tmo_o;
    logic [63:1]    err_adr_o;
    logic           err_clr_i;

    int total = 0;
    int bad   = 0;

    wb_addr_decoder #(
        .NSLAVES (NS),
        .FBITS   (4),
        .FLSB    (56),
        .IDS     ({ROM_ID, KIA_ID, GPIA_ID, RAM_ID}),
        .TMO     (8),
        .DW      (DW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .m_adr_i     (m_adr_i),
        .m_cyc_i     (m_cyc_i),
        .m_stb_i     (m_stb_i),
        .m_dat_o     (m_dat_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .s_cyc_o     (s_cyc_o),
        .s_stb_o     (s_stb_o),
        .s_ack_i     (s_ack_i),
        .s_dat_i     (s_dat_i),
        .err_valid_o (err_valid_o),
        .err_tmo_o   (err_tmo_o),
        .err_adr_o   (err_adr_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  top;
        logic [3:0]  stb;
        logic [15:0] dat;
        logic        err;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        m_cyc_i   = 1'b0;
        m_stb_i   = 1'b0;
        s_ack_i   = '0;
        err_clr_i = 1'b0;
    endtask

    task automatic request(input logic [7:0] top);
        m_adr_i = {top, LOWB};
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
    endtask

    task automatic clear_err();
        tick();
        drive_idle();
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        #4;
        chk("err_cleared", 64'(err_valid_o), 64'd0);
    endtask

    initial begin
        vecs[0] = '{top: 8'h00, stb: 4'b0001, dat: 16'h1234, err: 1'b0};
        vecs[1] = '{top: 8'h01, stb: 4'b0010, dat: 16'hBEEF, err: 1'b0};
        vecs[2] = '{top: 8'hA2, stb: 4'b0100, dat: 16'hCAFE, err: 1'b0};
        vecs[3] = '{top: 8'h0F, stb: 4'b1000, dat: 16'hF00D, err: 1'b0};
        vecs[4] = '{top: 8'h35, stb: 4'b0000, dat: 16'h35EE, err: 1'b1};
        vecs[5] = '{top: 8'hC7, stb: 4'b0000, dat: 16'hC7EE, err: 1'b1};

        s_dat_i = {16'hF00D, 16'hCAFE, 16'hBEEF, 16'h1234};
        m_adr_i = '0;
        reset_i = 1'b0;
        drive_idle();

        // Reset state
        #12;
        chk("rst_s_stb", 64'(s_stb_o), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_m_ack", 64'(m_ack_o), 64'd0);
        chk("rst_m_err", 64'(m_err_o), 64'd0);
        chk("rst_m_dat", 64'(m_dat_o), 64'd0);
        chk("rst_err_valid", 64'(err_valid_o), 64'd0);
        chk("rst_err_adr", 64'(err_adr_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b1;

        // Table: decode and response for claimed and unclaimed addresses
        for (int i = 0; i < 6; i++) begin
            tick();
            request(vecs[i].top);
            #4;
            chk("v_idle_stb", 64'(s_stb_o), 64'd0);
            chk("v_idle_ack", 64'(m_ack_o), 64'd0);
            tick();
            #4;
            if (vecs[i].err) begin
                chk("v_resp_ack", 64'(m_ack_o), 64'd1);
                chk("v_resp_err", 64'(m_err_o), 64'd1);
                chk("v_resp_dat", 64'(m_dat_o), 64'(vecs[i].dat));
                chk("v_resp_stb", 64'(s_stb_o), 64'd0);
                chk("v_err_valid", 64'(err_valid_o), 64'd1);
                chk("v_err_tmo", 64'(err_tmo_o), 64'd0);
                chk("v_err_adr", 64'(err_adr_o), 64'({vecs[i].top, LOWB}));
                tick();
                drive_idle();
                #4;
                chk("v_after_resp_ack", 64'(m_ack_o), 64'd0);
                clear_err();
            end else begin
                chk("v_busy_stb", 64'(s_stb_o), 64'(vecs[i].stb));
                chk("v_busy_cyc", 64'(s_cyc_o), 64'(vecs[i].stb));
                chk("v_busy_noack", 64'(m_ack_o), 64'd0);
                tick();
                #4;
                chk("v_wait_noack", 64'(m_ack_o), 64'd0);
                tick();
                s_ack_i = vecs[i].stb;
                #4;
                chk("v_ack", 64'(m_ack_o), 64'd1);
                chk("v_ack_err", 64'(m_err_o), 64'd0);
                chk("v_ack_dat", 64'(m_dat_o), 64'(vecs[i].dat));
                tick();
                drive_idle();
                #4;
                chk("v_done_stb", 64'(s_stb_o), 64'd0);
                chk("v_done_ack", 64'(m_ack_o), 64'd0);
            end
        end

        // Timeout on slave 0 with TMO=8: error response in cycle 10
        tick();
        request(8'h10);
        s_ack_i = 4'b1110;
        #4;
        chk("to_idle_stb", 64'(s_stb_o), 64'd0);
        for (int c = 2; c <= 9; c++) begin
            tick();
            #4;
            chk("to_busy_stb", 64'(s_stb_o), 64'd1);
            chk("to_busy_noack", 64'(m_ack_o), 64'd0);
        end
        tick();
        #4;
        chk("to_ack", 64'(m_ack_o), 64'd1);
        chk("to_err", 64'(m_err_o), 64'd1);
        chk("to_stb_drop", 64'(s_stb_o), 64'd0);
        chk("to_dat", 64'(m_dat_o), 64'h10EE);
        chk("to_err_valid", 64'(err_valid_o), 64'd1);
        chk("to_err_tmo", 64'(err_tmo_o), 64'd1);
        chk("to_err_adr", 64'(err_adr_o), 64'({8'h10, LOWB}));
        clear_err();

        // Abort: strobe dropped in the third BUSY cycle, late ack ignored
        tick();
        request(8'h40);
        tick();
        #4;
        chk("ab_busy1_stb", 64'(s_stb_o), 64'd1);
        tick();
        #4;
        chk("ab_busy2_stb", 64'(s_stb_o), 64'd1);
        tick();
        m_stb_i = 1'b0;
        #4;
        chk("ab_drop_stb", 64'(s_stb_o), 64'd0);
        chk("ab_drop_ack", 64'(m_ack_o), 64'd0);
        tick();
        s_ack_i = 4'b0001;
        #4;
        chk("ab_late_ack", 64'(m_ack_o), 64'd0);
        chk("ab_late_stb", 64'(s_stb_o), 64'd0);
        tick();
        drive_idle();
        #4;
        chk("ab_no_ack", 64'(m_ack_o), 64'd0);
        chk("ab_err_valid", 64'(err_valid_o), 64'd0);

        // Sticky capture: second fault does not overwrite the first
        tick();
        request(8'h23);
        tick();
        #4;
        chk("st1_err_adr", 64'(err_adr_o), 64'({8'h23, LOWB}));
        tick();
        drive_idle();
        tick();
        request(8'h73);
        tick();
        #4;
        chk("st2_ack", 64'(m_ack_o), 64'd1);
        chk("st2_dat", 64'(m_dat_o), 64'h73EE);
        chk("st2_err_valid", 64'(err_valid_o), 64'd1);
        chk("st2_err_adr", 64'(err_adr_o), 64'({8'h23, LOWB}));
        tick();
        drive_idle();
        // Clear coincides with the third fault's capture edge
        tick();
        request(8'h94);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        #4;
        chk("st3_err_valid", 64'(err_valid_o), 64'd1);
        chk("st3_err_adr", 64'(err_adr_o), 64'({8'h94, LOWB}));
        chk("st3_err_tmo", 64'(err_tmo_o), 64'd0);
        tick();
        drive_idle();

        // Reset asserted mid-BUSY, then normal decode after release
        tick();
        request(8'h01);
        tick();
        s_ack_i = 4'b0010;
        #2;
        chk("rb_pre_ack", 64'(m_ack_o), 64'd1);
        chk("rb_pre_stb", 64'(s_stb_o), 64'd2);
        #1;
        reset_i = 1'b0;
        #1;
        chk("rb_stb_async", 64'(s_stb_o), 64'd0);
        chk("rb_ack_async", 64'(m_ack_o), 64'd0);
        chk("rb_err_valid", 64'(err_valid_o), 64'd0);
        drive_idle();
        tick();
        reset_i = 1'b1;
        tick();
        request(8'hA2);
        tick();
        #4;
        chk("rb_next_stb", 64'(s_stb_o), 64'd4);
        chk("rb_next_noack", 64'(m_ack_o), 64'd0);
        tick();
        s_ack_i = 4'b0100;
        #4;
        chk("rb_next_ack", 64'(m_ack_o), 64'd1);
        chk("rb_next_dat", 64'(m_dat_o), 64'hCAFE);
        tick();
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
